// File: rtl/fnd_pkg.sv
// Shared constants, FSM state type and saturation helper for the FND display arbiter.
package fnd_pkg;

    localparam int unsigned FND_MAX_COUNT = 9999;
    localparam int unsigned FND_CNT_W     = 14;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        OPEN
    } arb_state_t;

    function automatic logic [FND_CNT_W-1:0] fnd_sat(input logic [FND_CNT_W-1:0] v);
        return (v > FND_CNT_W'(FND_MAX_COUNT)) ? FND_CNT_W'(FND_MAX_COUNT) : v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester (req & mask) found scanning from ptr upward, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(ptr) + int'(k)) % int'(NUM_REQ));
            if (!found && req[idx] && mask[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fnd_display_arbiter.sv
// Arbitrates NUM_REQ value sources onto one FND display with a minimum ownership hold.
// Optional idle blanking is compiled in with the FND_ARB_BLANK_EN macro.
module fnd_display_arbiter
    import fnd_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned HOLD_CYCLES  = 100_000_000,
    parameter int unsigned IDLE_TIMEOUT = 500_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*FND_CNT_W-1:0] req_value,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [FND_CNT_W-1:0]         disp_count,
    output logic [$clog2(NUM_REQ)-1:0]   disp_src,
    output logic                         disp_blank
);

    localparam int unsigned SRC_W = $clog2(NUM_REQ);

    arb_state_t           state, state_nxt;
    logic [SRC_W-1:0]     owner, rr_ptr, arb_ptr, win_idx;
    logic [31:0]          hold_cnt;
    logic [NUM_REQ-1:0]   owner_oh, arb_mask, gnt, ready_c;
    logic                 others_valid, xfer, take;
    logic [FND_CNT_W-1:0] win_value;

    function automatic logic [SRC_W-1:0] ptr_inc(input logic [SRC_W-1:0] p);
        return (int'(p) == int'(NUM_REQ) - 1) ? '0 : p + 1'b1;
    endfunction

    assign owner_oh     = NUM_REQ'(1) << owner;
    assign others_valid = |(req_valid & ~owner_oh);

    always_comb begin
        arb_mask = '1;
        arb_ptr  = rr_ptr;
        if (state == OPEN) begin
            arb_mask = ~owner_oh;
            arb_ptr  = ptr_inc(owner);
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (SRC_W)
    ) u_rr (
        .req  (req_valid),
        .mask (arb_mask),
        .ptr  (arb_ptr),
        .gnt  (gnt)
    );

    // Output process: ready is one-hot and forced low during reset so no transfer slips in.
    always_comb begin
        ready_c = '0;
        case (state)
            IDLE:    ready_c = gnt;
            HOLD:    ready_c = owner_oh;
            OPEN:    ready_c = others_valid ? gnt : owner_oh;
            default: ready_c = '0;
        endcase
        if (rst) ready_c = '0;
    end

    assign req_ready = ready_c;
    assign xfer      = |(req_valid & ready_c);

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ready_c[i]) win_idx = SRC_W'(i);
        end
    end

    assign win_value = req_value[FND_CNT_W*win_idx +: FND_CNT_W];
    assign take      = xfer && ((state == IDLE) || (state == OPEN && win_idx != owner));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = HOLD;
            HOLD:    if (hold_cnt == 32'd0) state_nxt = OPEN;
            OPEN:    if (take) state_nxt = HOLD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            hold_cnt   <= '0;
            disp_count <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                owner    <= win_idx;
                rr_ptr   <= ptr_inc(win_idx);
                hold_cnt <= 32'(HOLD_CYCLES - 1);
            end else if (state == HOLD && hold_cnt != 32'd0) begin
                hold_cnt <= hold_cnt - 32'd1;
            end
            if (xfer) disp_count <= fnd_sat(win_value);
        end
    end

    assign disp_src = owner;

`ifdef FND_ARB_BLANK_EN
    logic [31:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (rst)                             idle_cnt <= '0;
        else if (xfer)                       idle_cnt <= '0;
        else if (idle_cnt != IDLE_TIMEOUT)   idle_cnt <= idle_cnt + 32'd1;
    end

    assign disp_blank = (idle_cnt == IDLE_TIMEOUT);
`else
    assign disp_blank = 1'b0;
`endif

endmodule

// File: tb/tb_fnd_display_arbiter.sv
// Directed scoreboard bench for fnd_display_arbiter (NUM_REQ=2, HOLD_CYCLES=4, IDLE_TIMEOUT=8).
module tb_fnd_display_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [27:0] req_value;
    logic [1:0]  req_ready;
    logic [13:0] disp_count;
    logic [0:0]  disp_src;
    logic        disp_blank;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic [13:0] cnt;
        logic        src;
    } exp_t;

    exp_t sb[$];

`ifdef FND_ARB_BLANK_EN
    localparam logic BLANK_ON = 1'b1;
`else
    localparam logic BLANK_ON = 1'b0;
`endif

    fnd_display_arbiter #(
        .NUM_REQ      (2),
        .HOLD_CYCLES  (4),
        .IDLE_TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_value  (req_value),
        .req_ready  (req_ready),
        .disp_count (disp_count),
        .disp_src   (disp_src),
        .disp_blank (disp_blank)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [13:0] v0, input logic [13:0] v1);
        req_valid = v;
        req_value = {v1, v0};
        #1;
    endtask

    task automatic push(input logic [13:0] raw, input logic src);
        exp_t e;
        e.cnt = (raw > 14'd9999) ? 14'd9999 : raw;
        e.src = src;
        sb.push_back(e);
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: scoreboard empty, observed count %0d", tag, disp_count);
        end else begin
            e = sb.pop_front();
            check({tag, "_count"}, 32'(disp_count), 32'(e.cnt));
            check({tag, "_src"},   32'(disp_src),   32'(e.src));
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(2'b11, 14'd5, 14'd6);
        check("rst_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        check("rst_count", 32'(disp_count), 32'd0);
        check("rst_src",   32'(disp_src),   32'd0);
        check("rst_blank", 32'(disp_blank), 32'd0);

        // First grant from IDLE
        rst = 1'b0;
        drive(2'b01, 14'd1234, 14'd0);
        check("idle_ready0", 32'(req_ready), 32'd1);
        push(14'd1234, 1'b0);
        tick();
        check_sb("first_xfer");

        // Non-owner stalls through the hold, then preempts in OPEN
        drive(2'b10, 14'd0, 14'd42);
        for (int k = 0; k < 4; k++) begin
            check("hold_stall", 32'(req_ready), 32'd1);
            tick();
        end
        check("open_ready1", 32'(req_ready), 32'd2);
        push(14'd42, 1'b1);
        tick();
        check_sb("preempt");

        // Saturation by the owner during HOLD
        drive(2'b10, 14'd0, 14'd16383);
        check("sat_ready", 32'(req_ready), 32'd2);
        push(14'd16383, 1'b1);
        tick();
        check_sb("saturate");

        drive(2'b00, 14'd0, 14'd0);
        for (int k = 0; k < 3; k++) tick();

        // OPEN with only owner valid: owner keeps the display
        drive(2'b10, 14'd0, 14'd500);
        check("open_owner", 32'(req_ready), 32'd2);
        push(14'd500, 1'b1);
        tick();
        check_sb("open_owner_xfer");

        drive(2'b11, 14'd7, 14'd500);
        check("open_preempt", 32'(req_ready), 32'd1);
        push(14'd7, 1'b0);
        tick();
        check_sb("preempt_back");

        // Idle blanking
        drive(2'b00, 14'd0, 14'd0);
        for (int k = 0; k < 7; k++) tick();
        check("blank_before", 32'(disp_blank), 32'd0);
        tick();
        check("blank_timeout", 32'(disp_blank), 32'(BLANK_ON));
        drive(2'b01, 14'd100, 14'd0);
        check("blank_ready", 32'(req_ready), 32'd1);
        push(14'd100, 1'b0);
        tick();
        check_sb("blank_xfer");
        check("blank_cleared", 32'(disp_blank), 32'd0);

        // Reset during HOLD discards ownership and the offered transfer
        drive(2'b10, 14'd0, 14'd55);
        check("pre_rst_ready", 32'(req_ready), 32'd2);
        push(14'd55, 1'b1);
        tick();
        check_sb("pre_rst_xfer");
        rst = 1'b1;
        drive(2'b10, 14'd0, 14'd777);
        check("rst_hold_ready", 32'(req_ready), 32'd0);
        tick();
        check("rst_hold_count", 32'(disp_count), 32'd0);
        check("rst_hold_src",   32'(disp_src),   32'd0);
        rst = 1'b0;

        // Back in IDLE with pointer 0: both valid -> 0, then 1, then 0
        drive(2'b11, 14'd321, 14'd654);
        check("rr_first", 32'(req_ready), 32'd1);
        push(14'd321, 1'b0);
        tick();
        check_sb("rr0");
        for (int k = 0; k < 4; k++) begin
            check("rr_hold0", 32'(req_ready), 32'd1);
            push(14'd321, 1'b0);
            tick();
            check_sb("rr_hold0_xfer");
        end
        check("rr_second", 32'(req_ready), 32'd2);
        push(14'd654, 1'b1);
        tick();
        check_sb("rr1");
        for (int k = 0; k < 4; k++) begin
            check("rr_hold1", 32'(req_ready), 32'd2);
            push(14'd654, 1'b1);
            tick();
            check_sb("rr_hold1_xfer");
        end
        check("rr_third", 32'(req_ready), 32'd1);
        push(14'd321, 1'b0);
        tick();
        check_sb("rr0_again");
        check("blank_final", 32'(disp_blank), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
